// File: rtl/ex_mul_div_unit.sv
// Execute-stage multiply/divide unit.
// Runs iterative shift-add multiply and restoring divide, one result bit per
// cycle, owns the architectural HI/LO registers and serves MFHI/MFLO/MTHI/MTLO.
// While an operation is in flight the unit stalls EX and the upstream stages.
`timescale 1ns/1ps

module ex_mul_div_unit #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic        exceptClear,
    input  logic [3:0]  ex_mdOperation,
    input  logic [31:0] ex_operandA,
    input  logic [31:0] ex_operandB,
    output logic        ex_mdStall,
    output logic [31:0] ex_mdResult,
    output logic [31:0] ex_hi,
    output logic [31:0] ex_lo
);

    localparam int            CW        = $clog2(ITER);
    localparam logic [CW-1:0] LAST_ITER = CW'(ITER - 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } MdState;

    MdState state;
    MdState stateNext;

    logic [CW-1:0] counter;
    logic [63:0]   mulAcc;
    logic [32:0]   divRem;
    logic [31:0]   divQuo;
    logic [31:0]   magA;
    logic [31:0]   magB;
    logic [31:0]   rawA;
    logic          negResult;
    logic          negRem;
    logic          divByZero;
    logic [31:0]   hiReg;
    logic [31:0]   loReg;

    // Decode of the incoming operation
    logic          isMulStart;
    logic          isDivStart;
    logic          isStart;
    logic          isSignedOp;
    logic          aNeg;
    logic          bNeg;
    logic [31:0]   magAIn;
    logic [31:0]   magBIn;

    assign isMulStart = (ex_mdOperation == OP_MULT) || (ex_mdOperation == OP_MULTU);
    assign isDivStart = (ex_mdOperation == OP_DIV)  || (ex_mdOperation == OP_DIVU);
    assign isStart    = isMulStart || isDivStart;
    assign isSignedOp = (ex_mdOperation == OP_MULT) || (ex_mdOperation == OP_DIV);
    assign aNeg       = isSignedOp && ex_operandA[31];
    assign bNeg       = isSignedOp && ex_operandB[31];
    assign magAIn     = aNeg ? (32'd0 - ex_operandA) : ex_operandA;
    assign magBIn     = bNeg ? (32'd0 - ex_operandB) : ex_operandB;

    // One shift-add step: the multiplier sits in the low half of the
    // accumulator and is consumed LSB first as the product shifts in above it
    logic [32:0] mulSum;
    logic [63:0] mulAccNext;

    assign mulSum     = {1'b0, mulAcc[63:32]} + (mulAcc[0] ? {1'b0, magA} : 33'd0);
    assign mulAccNext = {mulSum, mulAcc[31:1]};

    // One restoring-divide step: shift in the next dividend bit and keep the
    // trial subtraction only when it does not borrow
    logic [33:0] divShifted;
    logic [33:0] divTrial;
    logic [32:0] divRemNext;
    logic [31:0] divQuoNext;

    assign divShifted = {divRem, divQuo[31]};
    assign divTrial   = divShifted - {2'b00, magB};
    assign divRemNext = divTrial[33] ? divShifted[32:0] : divTrial[32:0];
    assign divQuoNext = {divQuo[30:0], ~divTrial[33]};

    // Sign fix-up applied to the value produced by the final iteration
    logic [63:0] mulFinal;
    logic [31:0] quoFinal;
    logic [31:0] remFinal;

    assign mulFinal = negResult ? (64'd0 - mulAccNext) : mulAccNext;
    assign quoFinal = negResult ? (32'd0 - divQuoNext) : divQuoNext;
    assign remFinal = negRem    ? (32'd0 - divRemNext[31:0]) : divRemNext[31:0];

    // State register; only advances when the pipeline is enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (cpu_en) begin
            state <= stateNext;
        end
    end

    // Next-state selection; a flush always returns to IDLE
    always_comb begin
        stateNext = state;
        if (exceptClear) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (isMulStart) begin
                        stateNext = MUL;
                    end else if (isDivStart) begin
                        stateNext = DIV;
                    end
                end
                MUL: begin
                    if (counter == LAST_ITER) begin
                        stateNext = DONE;
                    end
                end
                DIV: begin
                    if (counter == LAST_ITER) begin
                        stateNext = DONE;
                    end
                end
                DONE: begin
                    stateNext = IDLE;
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

    // Datapath: operand latch on issue, one iteration per cycle, HI/LO commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter   <= '0;
            mulAcc    <= '0;
            divRem    <= '0;
            divQuo    <= '0;
            magA      <= '0;
            magB      <= '0;
            rawA      <= '0;
            negResult <= 1'b0;
            negRem    <= 1'b0;
            divByZero <= 1'b0;
            hiReg     <= '0;
            loReg     <= '0;
        end else if (cpu_en) begin
            if (exceptClear) begin
                counter <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (isStart) begin
                            counter   <= '0;
                            magA      <= magAIn;
                            magB      <= magBIn;
                            rawA      <= ex_operandA;
                            negResult <= aNeg ^ bNeg;
                            negRem    <= aNeg;
                            divByZero <= (ex_operandB == 32'd0);
                            mulAcc    <= {32'd0, magBIn};
                            divRem    <= '0;
                            divQuo    <= magAIn;
                        end else if (ex_mdOperation == OP_MTHI) begin
                            hiReg <= ex_operandA;
                        end else if (ex_mdOperation == OP_MTLO) begin
                            loReg <= ex_operandA;
                        end
                    end
                    MUL: begin
                        mulAcc  <= mulAccNext;
                        counter <= counter + 1'b1;
                        if (counter == LAST_ITER) begin
                            hiReg <= mulFinal[63:32];
                            loReg <= mulFinal[31:0];
                        end
                    end
                    DIV: begin
                        divRem  <= divRemNext;
                        divQuo  <= divQuoNext;
                        counter <= counter + 1'b1;
                        if (counter == LAST_ITER) begin
                            if (divByZero) begin
                                hiReg <= rawA;
                                loReg <= 32'hFFFF_FFFF;
                            end else begin
                                hiReg <= remFinal;
                                loReg <= quoFinal;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Stall and move-from-HI/LO result are purely combinational
    always_comb begin
        ex_mdStall  = 1'b0;
        ex_mdResult = 32'd0;
        if (!rst) begin
            ex_mdStall = ((state == IDLE) && isStart) || (state == MUL) || (state == DIV);
        end
        if (ex_mdOperation == OP_MFHI) begin
            ex_mdResult = hiReg;
        end else if (ex_mdOperation == OP_MFLO) begin
            ex_mdResult = loReg;
        end
    end

    assign ex_hi = hiReg;
    assign ex_lo = loReg;

endmodule

// File: tb/tb_ex_mul_div_unit.sv
// Testbench for ex_mul_div_unit.
// A behavioural model (plain arithmetic plus a remaining-cycle count) is
// compared against the DUT on every falling edge, and directed vectors are
// also checked against hand-computed literal values.
`timescale 1ns/1ps

module tb_ex_mul_div_unit;

    localparam int ITER = 32;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic        clk;
    logic        rst;
    logic        cpu_en;
    logic        exceptClear;
    logic [3:0]  ex_mdOperation;
    logic [31:0] ex_operandA;
    logic [31:0] ex_operandB;
    logic        ex_mdStall;
    logic [31:0] ex_mdResult;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;

    int vectorCount = 0;
    int missCount   = 0;
    bit checkOn     = 1'b0;

    // Model state: architectural HI/LO, pending result, cycles left in flight
    logic [31:0] mHi    = '0;
    logic [31:0] mLo    = '0;
    logic [63:0] mPend  = '0;
    int          mBusy  = 0;
    bit          mDone  = 1'b0;

    ex_mul_div_unit #(.ITER(ITER)) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_en         (cpu_en),
        .exceptClear    (exceptClear),
        .ex_mdOperation (ex_mdOperation),
        .ex_operandA    (ex_operandA),
        .ex_operandB    (ex_operandB),
        .ex_mdStall     (ex_mdStall),
        .ex_mdResult    (ex_mdResult),
        .ex_hi          (ex_hi),
        .ex_lo          (ex_lo)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural result of a mul/div op as {HI, LO}
    function automatic logic [63:0] refResult(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int          sa;
        int          sb;
        int          sq;
        int          sr;
        longint      sp;
        logic [63:0] r;
        sa = a;
        sb = b;
        r  = '0;
        case (op)
            OP_MULT: begin
                sp = longint'(sa) * longint'(sb);
                r  = 64'(sp);
            end
            OP_MULTU: begin
                r = {32'd0, a} * {32'd0, b};
            end
            OP_DIV: begin
                if (b == 32'd0) begin
                    r = {a, 32'hFFFF_FFFF};
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r = {32'd0, 32'h8000_0000};
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    r  = {32'(sr), 32'(sq)};
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) begin
                    r = {a, 32'hFFFF_FFFF};
                end else begin
                    r = {a % b, a / b};
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Behavioural model advanced on the same edges as the DUT
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mHi   = '0;
            mLo   = '0;
            mPend = '0;
            mBusy = 0;
            mDone = 1'b0;
        end else if (cpu_en) begin
            if (exceptClear) begin
                mBusy = 0;
                mDone = 1'b0;
            end else if (mBusy > 0) begin
                mBusy = mBusy - 1;
                if (mBusy == 0) begin
                    mHi   = mPend[63:32];
                    mLo   = mPend[31:0];
                    mDone = 1'b1;
                end
            end else if (mDone) begin
                mDone = 1'b0;
            end else if (ex_mdOperation >= OP_MULT && ex_mdOperation <= OP_DIVU) begin
                mPend = refResult(ex_mdOperation, ex_operandA, ex_operandB);
                mBusy = ITER;
            end else if (ex_mdOperation == OP_MTHI) begin
                mHi = ex_operandA;
            end else if (ex_mdOperation == OP_MTLO) begin
                mLo = ex_operandA;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Compare process: DUT against model on every falling edge
    always @(negedge clk) begin
        logic        expStall;
        logic [31:0] expResult;
        if (checkOn) begin
            expStall  = !rst && ((mBusy > 0) ||
                        (!mDone && ex_mdOperation >= OP_MULT && ex_mdOperation <= OP_DIVU));
            expResult = (ex_mdOperation == OP_MFHI) ? mHi :
                        (ex_mdOperation == OP_MFLO) ? mLo : 32'd0;
            checkOutput("model stall",  32'(ex_mdStall), 32'(expStall));
            checkOutput("model hi",     ex_hi,           mHi);
            checkOutput("model lo",     ex_lo,           mLo);
            checkOutput("model result", ex_mdResult,     expResult);
        end
    end

    // Drive one cycle of inputs, ending just after the next rising edge
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic clr);
        ex_mdOperation = op;
        ex_operandA    = a;
        ex_operandB    = b;
        exceptClear    = clr;
        @(posedge clk);
        #1;
    endtask

    // Issue a mul/div, hold it while stalled, optionally freeze cpu_en, then
    // check stall length and HI/LO in the DONE cycle and return to IDLE
    task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int expStall, input logic [31:0] expHi, input logic [31:0] expLo,
                         input int freezeAt, input int freezeLen);
        int stallCycles;
        stallCycles    = 0;
        ex_mdOperation = op;
        ex_operandA    = a;
        ex_operandB    = b;
        exceptClear    = 1'b0;
        cpu_en         = 1'b1;
        #1;
        while (ex_mdStall && stallCycles < 200) begin
            cpu_en = !(freezeLen > 0 && stallCycles >= freezeAt && stallCycles < freezeAt + freezeLen);
            stallCycles++;
            @(posedge clk);
            #1;
        end
        cpu_en = 1'b1;
        checkOutput({tag, " stall cycles"}, 32'(stallCycles), 32'(expStall));
        checkOutput({tag, " hi"}, ex_hi, expHi);
        checkOutput({tag, " lo"}, ex_lo, expLo);
        applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
    endtask

    // Flush a MULT 3x4 after clrAt cycles of stall; HI/LO must be untouched
    task automatic abortRun(input string tag, input int clrAt);
        applyStimulus(OP_MTHI, 32'h11, 32'd0, 1'b0);
        applyStimulus(OP_MTLO, 32'h22, 32'd0, 1'b0);
        ex_mdOperation = OP_MULT;
        ex_operandA    = 32'd3;
        ex_operandB    = 32'd4;
        exceptClear    = 1'b0;
        for (int i = 0; i < clrAt; i++) begin
            @(posedge clk);
            #1;
        end
        exceptClear = 1'b1;
        @(posedge clk);
        #1;
        exceptClear    = 1'b0;
        ex_mdOperation = OP_NONE;
        #1;
        checkOutput({tag, " stall"}, 32'(ex_mdStall), 32'd0);
        checkOutput({tag, " hi"}, ex_hi, 32'h11);
        checkOutput({tag, " lo"}, ex_lo, 32'h22);
        applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
    endtask

    // Watchdog so the bench always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, limit 200000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence
    initial begin
        rst            = 1'b1;
        cpu_en         = 1'b1;
        exceptClear    = 1'b0;
        ex_mdOperation = OP_NONE;
        ex_operandA    = '0;
        ex_operandB    = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOn = 1'b1;
        rst     = 1'b0;
        #1;
        checkOutput("reset stall", 32'(ex_mdStall), 32'd0);
        checkOutput("reset hi", ex_hi, 32'd0);
        checkOutput("reset lo", ex_lo, 32'd0);
        applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);

        runOp("MULT -3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0);
        runOp("MULTU max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0);

        ex_mdOperation = OP_MFHI;
        #1;
        checkOutput("MFHI result", ex_mdResult, 32'hFFFF_FFFE);
        applyStimulus(OP_MFHI, 32'd0, 32'd0, 1'b0);
        ex_mdOperation = OP_MFLO;
        #1;
        checkOutput("MFLO result", ex_mdResult, 32'h0000_0001);
        applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);

        runOp("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
        runOp("DIVU 5/0", OP_DIVU, 32'd5, 32'd0, 33, 32'd5, 32'hFFFF_FFFF, 0, 0);
        runOp("DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000, 0, 0);
        runOp("DIV -9/0", OP_DIV, 32'hFFFF_FFF7, 32'd0, 33, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 0, 0);
        runOp("DIV 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD, 0, 0);

        abortRun("abort iter10", 11);
        abortRun("abort final", 32);

        applyStimulus(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b1);
        checkOutput("clear beats MTHI", ex_hi, 32'h11);
        applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);

        runOp("DIVU 100/7 freeze", OP_DIVU, 32'd100, 32'd7, 38, 32'd2, 32'd14, 10, 5);

        ex_mdOperation = OP_DIV;
        ex_operandA    = 32'd1000;
        ex_operandB    = 32'd3;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        #3;
        rst            = 1'b1;
        ex_mdOperation = OP_NONE;
        #1;
        checkOutput("async rst stall", 32'(ex_mdStall), 32'd0);
        checkOutput("async rst hi", ex_hi, 32'd0);
        checkOutput("async rst lo", ex_lo, 32'd0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        runOp("MULT 2x3", OP_MULT, 32'd2, 32'd3, 33, 32'd0, 32'd6, 0, 0);

        checkOn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
